exec_trace_streamer: RTL and testbench

//  Hardware counterpart of the top-level bench monitor: captures the processor's execution trace
//  (PCOut, Instruction, RegWriteData) on-chip each cycle, buffers it in a FIFO, and streams it out.

---
 rtl/exec_trace_streamer.sv | 143 ++++++++++++++
 tb/tb_exec_trace_streamer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_trace_streamer.sv
// Execution-trace capture FIFO plus a 3-word valid/ready streamer (PC, instruction, writeback).
// Records that arrive while the FIFO is full and nothing is leaving are counted as drops.
module exec_trace_streamer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [31:0]       PCOut,
  input  logic [31:0]       Instruction,
  input  logic [31:0]       RegWriteData,
  input  logic              CaptureEn,
  input  logic              Flush,
  input  logic              TxReady,
  output logic              TxValid,
  output logic [31:0]       TxData,
  output logic              TxLast,
  output logic [ADDR_W:0]   Count,
  output logic              Full,
  output logic              Empty,
  output logic [15:0]       DropCount
);

  typedef enum logic [1:0] {StIdle, StPc, StInstr, StWb} state_e;

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

  logic [95:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [15:0]       drop_q;
  state_e            state_q, state_d;
  // Only instruction and writeback are kept; the PC word goes straight to TxData on load.
  logic [63:0]       hold_q, hold_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_last_q, tx_last_d;
  logic [31:0]       tx_data_q, tx_data_d;
  logic              push, pop, drop, hs;
  logic [95:0]       head;

  assign Count     = count_q;
  assign Full      = (count_q == FullCount);
  assign Empty     = (count_q == '0);
  assign DropCount = drop_q;
  assign TxValid   = tx_valid_q;
  assign TxData    = tx_data_q;
  assign TxLast    = tx_last_q;

  assign head = mem_q[rd_ptr_q];
  assign hs   = tx_valid_q & TxReady;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    if (Flush) begin
      state_d    = StIdle;
      tx_valid_d = 1'b0;
      tx_last_d  = 1'b0;
      tx_data_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: pop = ~Empty;
        StPc: if (hs) begin
          state_d   = StInstr;
          tx_data_d = hold_q[63:32];
        end
        StInstr: if (hs) begin
          state_d   = StWb;
          tx_data_d = hold_q[31:0];
          tx_last_d = 1'b1;
        end
        StWb: if (hs) begin
          pop        = ~Empty;
          state_d    = StIdle;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          tx_data_d  = '0;
        end
        default: state_d = StIdle;
      endcase
      // Loading from IDLE or straight after a writeback handshake keeps the stream gap-free.
      if (pop) begin
        hold_d     = head[63:0];
        state_d    = StPc;
        tx_valid_d = 1'b1;
        tx_last_d  = 1'b0;
        tx_data_d  = head[95:64];
      end
    end
  end

  assign push = CaptureEn & ~Flush & (~Full | pop);
  assign drop = CaptureEn & ~Flush & Full & ~pop;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= {PCOut, Instruction, RegWriteData};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      state_q    <= StIdle;
      hold_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      tx_data_q  <= tx_data_d;
      if (Flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        drop_q   <= '0;
      end else begin
        count_q <= count_d;
        if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_exec_trace_streamer.sv
// Self-checking bench for exec_trace_streamer: a stream scoreboard plus table-driven records
// and hand-written sequences for latency, backpressure, overflow, full push+pop, flush and reset.
module tb_exec_trace_streamer;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic [31:0]       PCOut = '0;
  logic [31:0]       Instruction = '0;
  logic [31:0]       RegWriteData = '0;
  logic              CaptureEn = 1'b0;
  logic              Flush = 1'b0;
  logic              TxReady = 1'b0;
  logic              TxValid;
  logic [31:0]       TxData;
  logic              TxLast;
  logic [ADDR_W:0]   Count;
  logic              Full;
  logic              Empty;
  logic [15:0]       DropCount;

  exec_trace_streamer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .PCOut(PCOut), .Instruction(Instruction),
    .RegWriteData(RegWriteData), .CaptureEn(CaptureEn), .Flush(Flush), .TxReady(TxReady),
    .TxValid(TxValid), .TxData(TxData), .TxLast(TxLast), .Count(Count), .Full(Full),
    .Empty(Empty), .DropCount(DropCount)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  logic [32:0] sb[$];   // {last, word}
  logic [32:0] mon_exp;

  typedef struct {
    logic [31:0] pc, instr, wb;
    logic [31:0] exp_pc, exp_instr, exp_wb;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_rec(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] wb);
    sb.push_back({1'b0, pc});
    sb.push_back({1'b0, ins});
    sb.push_back({1'b1, wb});
  endtask

  task automatic capture(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] wb,
                         input bit kept);
    PCOut = pc;
    Instruction = ins;
    RegWriteData = wb;
    CaptureEn = 1'b1;
    if (kept) push_rec(pc, ins, wb);
    step();
    CaptureEn = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || TxValid) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0 || TxValid) begin
      failures++;
      $display("FAIL drain: got %0d words pending expected 0", sb.size());
    end
  endtask

  // Scoreboard: every accepted beat must match the oldest expected word.
  always @(negedge Clk) begin
    if (Reset_n && TxValid && TxReady) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got %h expected no word", TxData);
      end else begin
        mon_exp = sb.pop_front();
        chk("stream_data", TxData, mon_exp[31:0]);
        chk("stream_last", 32'(TxLast), 32'(mon_exp[32]));
      end
    end
  end

  initial begin
    bit found;
    vecs[0] = '{32'h0000_0100, 32'h0000_0013, 32'h1111_1111,
                32'h0000_0100, 32'h0000_0013, 32'h1111_1111};
    vecs[1] = '{32'h0000_0104, 32'h00A0_0093, 32'h0000_000A,
                32'h0000_0104, 32'h00A0_0093, 32'h0000_000A};
    vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0000,
                32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{32'h8000_0000, 32'h5555_AAAA, 32'hAAAA_5555,
                32'h8000_0000, 32'h5555_AAAA, 32'hAAAA_5555};

    // Reset values, checked while reset is still asserted.
    #12;
    chk("rst_valid", 32'(TxValid), 32'd0);
    chk("rst_last", 32'(TxLast), 32'd0);
    chk("rst_data", TxData, 32'd0);
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_empty", 32'(Empty), 32'd1);
    chk("rst_full", 32'(Full), 32'd0);
    chk("rst_drop", 32'(DropCount), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step();

    // Table-driven records captured back to back, streamed with TxReady high.
    TxReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      PCOut = vecs[i].pc;
      Instruction = vecs[i].instr;
      RegWriteData = vecs[i].wb;
      CaptureEn = 1'b1;
      push_rec(vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].exp_wb);
      step();
    end
    CaptureEn = 1'b0;
    wait_drain(40);

    // Single record: latency and word order.
    step();
    capture(32'h0000_0004, 32'h2008_0005, 32'h0000_0005, 1'b1);
    chk("lat_not_yet", 32'(TxValid), 32'd0);
    chk("lat_count", 32'(Count), 32'd1);
    step();
    chk("w0_valid", 32'(TxValid), 32'd1);
    chk("w0_data", TxData, 32'h0000_0004);
    chk("w0_last", 32'(TxLast), 32'd0);
    chk("w0_count", 32'(Count), 32'd0);
    step();
    chk("w1_data", TxData, 32'h2008_0005);
    chk("w1_last", 32'(TxLast), 32'd0);
    step();
    chk("w2_data", TxData, 32'h0000_0005);
    chk("w2_last", 32'(TxLast), 32'd1);
    step();
    chk("w3_idle", 32'(TxValid), 32'd0);

    // Backpressure during the instruction word.
    TxReady = 1'b0;
    capture(32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0077, 1'b1);
    step();
    chk("bp_pc_valid", 32'(TxValid), 32'd1);
    TxReady = 1'b1;
    step();
    TxReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", 32'(TxValid), 32'd1);
      chk("bp_hold_data", TxData, 32'hDEAD_BEEF);
      chk("bp_hold_last", 32'(TxLast), 32'd0);
    end
    TxReady = 1'b1;
    wait_drain(20);

    // Overflow: 20 captures with the stream stalled, first 17 survive.
    TxReady = 1'b0;
    for (int i = 0; i < 20; i++)
      capture(32'(i * 4), 32'h1000_0000 | 32'(i), 32'hA000_0000 | 32'(i), i <= 16);
    chk("ovf_full", 32'(Full), 32'd1);
    chk("ovf_count", 32'(Count), 32'd16);
    chk("ovf_drop", 32'(DropCount), 32'd3);

    // Push and pop on the same edge while full: no drop, count unchanged.
    TxReady = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (TxValid && TxLast) begin
        found = 1'b1;
        capture(32'h0000_0400, 32'h4000_0000, 32'hB000_0000, 1'b1);
        chk("pp_count", 32'(Count), 32'd16);
        chk("pp_full", 32'(Full), 32'd1);
        chk("pp_drop", 32'(DropCount), 32'd3);
      end else begin
        step();
      end
    end
    chk("pp_reached_wb", 32'(found), 32'd1);
    wait_drain(200);
    chk("ovf_drained_empty", 32'(Empty), 32'd1);

    // Flush while streaming the instruction word with five records buffered.
    TxReady = 1'b0;
    for (int i = 0; i < 6; i++)
      capture(32'h0000_0200 + 32'(i * 4), 32'h2000_0000 | 32'(i), 32'hC000_0000 | 32'(i),
              i == 0);
    chk("fl_count5", 32'(Count), 32'd5);
    TxReady = 1'b1;
    step();
    TxReady = 1'b0;
    sb.delete();
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    chk("fl_valid", 32'(TxValid), 32'd0);
    chk("fl_last", 32'(TxLast), 32'd0);
    chk("fl_count", 32'(Count), 32'd0);
    chk("fl_empty", 32'(Empty), 32'd1);
    chk("fl_drop", 32'(DropCount), 32'd0);
    TxReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_quiet", 32'(TxValid), 32'd0);
    end
    capture(32'h0000_0300, 32'h3000_0000, 32'h0000_0333, 1'b1);
    wait_drain(20);

    // Asynchronous reset in the middle of a record.
    TxReady = 1'b0;
    capture(32'h0000_0500, 32'h5000_0000, 32'h0000_0555, 1'b0);
    step();
    chk("ar_pre_valid", 32'(TxValid), 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(TxValid), 32'd0);
    chk("ar_count", 32'(Count), 32'd0);
    chk("ar_empty", 32'(Empty), 32'd1);
    chk("ar_drop", 32'(DropCount), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
